// File: rtl/lab2_proc_fetch_pkg.sv
// Shared fetch-side types, sizes and helpers for the imem response path.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package lab2_proc_fetch_pkg;

  // Default response queue depth, which is also the fetch credit limit.
  localparam int c_imem_resp_entries = 2;

  // 4-byte memory response message (47 bits). The field order matches the
  // vc/mem-msgs layout: type, opaque, test, len, data.
  typedef struct packed {
    logic [2:0]  type_;
    logic [7:0]  opaque;
    logic [1:0]  test;
    logic [1:0]  len;
    logic [31:0] data;
  } mem_resp_4B_t;

  // Bits needed for a counter that can hold the values 0..n.
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/lab2_proc_imem_resp_queue.sv
// Circular-buffer FIFO with enqueue, dequeue and single-cycle flush.
// Latency: an enqueued word appears at deq_data the cycle after it is written.
// Backpressure: the caller gates enq; enq on full is accepted only with a same-cycle deq.
module lab2_proc_imem_resp_queue
  import lab2_proc_fetch_pkg::*;
#(
  parameter int p_entries = 2,
  parameter int p_width   = 32
)(
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            enq_val,
  input  logic [p_width-1:0]              enq_data,
  input  logic                            deq_en,
  input  logic                            flush,
  output logic [p_width-1:0]              deq_data,
  output logic [cnt_width(p_entries)-1:0] count,
  output logic                            full,
  output logic                            empty
);

  localparam int c_ptr_w = (p_entries > 1) ? $clog2(p_entries) : 1;
  localparam int c_cnt_w = cnt_width(p_entries);

  logic [p_width-1:0] mem [p_entries];
  logic [c_ptr_w-1:0] wr_ptr;
  logic [c_ptr_w-1:0] rd_ptr;
  logic               do_enq;
  logic               do_deq;

  // Pointers wrap modulo the depth, so non power-of-two depths also work.
  function automatic logic [c_ptr_w-1:0] ptr_inc(input logic [c_ptr_w-1:0] p);
    return (p == c_ptr_w'(p_entries - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full     = (count == c_cnt_w'(p_entries));
  assign empty    = (count == '0);
  assign do_enq   = enq_val && (!full || deq_en) && !flush;
  assign do_deq   = deq_en && !empty && !flush;
  assign deq_data = mem[rd_ptr];

  // Storage is left unreset; only pointers and count define validity.
  always_ff @(posedge clk) begin
    if (do_enq) mem[wr_ptr] <= enq_data;
  end

  // Pointer and occupancy tracking; flush empties the buffer in one cycle.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_enq) wr_ptr <= ptr_inc(wr_ptr);
      if (do_deq) rd_ptr <= ptr_inc(rd_ptr);
      if (do_enq && !do_deq)      count <= count + 1'b1;
      else if (!do_enq && do_deq) count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/lab2_proc_imem_resp_unit.sv
// Fetch response unit: credits, in-flight count, response buffering, squash drop.
// Latency: response to deq_val is 1 cycle, or 0 cycles with LAB2_PROC_IMEM_RESP_BYPASS_EN.
// Backpressure: credits (req_ok) reserve a slot per fetch; imemresp_rdy drops only when full.
module lab2_proc_imem_resp_unit
  import lab2_proc_fetch_pkg::*;
#(
  parameter int p_num_entries = c_imem_resp_entries
)(
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                imemreq_val,
  input  logic                                imemreq_rdy,
  output logic                                req_ok,
  input  logic                                imemresp_val,
  output logic                                imemresp_rdy,
  input  mem_resp_4B_t                        imemresp_msg,
  input  logic                                squash,
  output logic                                deq_val,
  input  logic                                deq_rdy,
  output logic [31:0]                         deq_data,
  output logic [cnt_width(p_num_entries)-1:0] num_outstanding
);

  localparam int           c_w     = cnt_width(p_num_entries);
  localparam logic [c_w:0] c_limit = (c_w + 1)'(p_num_entries);

  logic [c_w-1:0] outstanding;
  logic [c_w-1:0] drop_cnt;
  logic [c_w-1:0] q_count;
  logic [c_w:0]   inflight;
  logic [31:0]    q_head;
  logic [31:0]    resp_data;
  logic           q_full;
  logic           q_empty;
  logic           q_enq;
  logic           q_pop;
  logic           req_fire;
  logic           resp_fire;
  logic           deq_fire;
  logic           dropping;
  logic           unused_msg_bits;

  assign unused_msg_bits = ^{imemresp_msg.type_, imemresp_msg.opaque,
                             imemresp_msg.test, imemresp_msg.len};

  assign resp_data       = imemresp_msg.data;
  assign req_fire        = imemreq_val && imemreq_rdy;
  assign resp_fire       = imemresp_val && imemresp_rdy;
  assign deq_fire        = deq_val && deq_rdy;
  assign dropping        = squash || (drop_cnt != '0);
  assign inflight        = {1'b0, outstanding} + {1'b0, q_count};
  assign req_ok          = (inflight < c_limit);
  assign imemresp_rdy    = dropping || !q_full;
  assign num_outstanding = outstanding;

`ifdef LAB2_PROC_IMEM_RESP_BYPASS_EN
  logic bypass;
  assign bypass = q_empty && resp_fire && (drop_cnt == '0) && !squash;

  // Bypass steering: an arriving word goes straight to D when the queue is empty.
  always_comb begin
    deq_val  = !squash && (!q_empty || bypass);
    deq_data = q_empty ? resp_data : q_head;
    q_enq    = resp_fire && !dropping && !(bypass && deq_rdy);
    q_pop    = deq_fire && !q_empty;
  end
`else
  // Queued steering: D only ever sees the registered queue head.
  always_comb begin
    deq_val  = !squash && !q_empty;
    deq_data = q_head;
    q_enq    = resp_fire && !dropping;
    q_pop    = deq_fire;
  end
`endif

  lab2_proc_imem_resp_queue #(
    .p_entries (p_num_entries),
    .p_width   (32)
  ) u_queue (
    .clk      (clk),
    .reset    (reset),
    .enq_val  (q_enq),
    .enq_data (resp_data),
    .deq_en   (q_pop),
    .flush    (squash),
    .deq_data (q_head),
    .count    (q_count),
    .full     (q_full),
    .empty    (q_empty)
  );

  // In-flight request counter; a fetch issued in a squash cycle is the redirect and counts here.
  always_ff @(posedge clk) begin
    if (reset) begin
      outstanding <= '0;
    end else begin
      case ({req_fire, resp_fire})
        2'b10:   outstanding <= outstanding + 1'b1;
        2'b01:   outstanding <= outstanding - 1'b1;
        default: outstanding <= outstanding;
      endcase
    end
  end

  // Squash marks every older in-flight fetch (not yet answered) for discard.
  always_ff @(posedge clk) begin
    if (reset) begin
      drop_cnt <= '0;
    end else if (squash) begin
      drop_cnt <= resp_fire ? outstanding - 1'b1 : outstanding;
    end else if ((drop_cnt != '0) && resp_fire) begin
      drop_cnt <= drop_cnt - 1'b1;
    end
  end

`ifndef SYNTHESIS
  // The credit rule makes both of these unreachable with a well-behaved ctrl/imem.
  a_no_overflow: assert property (@(posedge clk) disable iff (reset)
    !(req_fire && !resp_fire && (outstanding == c_w'(p_num_entries))));
  a_no_underflow: assert property (@(posedge clk) disable iff (reset)
    !(resp_fire && (outstanding == '0)));
`endif

endmodule

// File: tb/tb_lab2_proc_imem_resp_unit.sv
// Directed bench for the fetch response unit (depth-2 and depth-4 instances).
// Inputs change 1 time unit after the rising edge, and outputs are checked 1 unit later.
// Expectations follow whether LAB2_PROC_IMEM_RESP_BYPASS_EN is defined.
module tb_lab2_proc_imem_resp_unit;
  import lab2_proc_fetch_pkg::*;

`ifdef LAB2_PROC_IMEM_RESP_BYPASS_EN
  localparam bit c_bypass = 1'b1;
`else
  localparam bit c_bypass = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  logic req_rdy = 1'b1;

  logic a_req_val, a_resp_val, a_squash, a_deq_rdy;
  logic a_req_ok, a_resp_rdy, a_deq_val;
  mem_resp_4B_t a_msg;
  logic [31:0] a_deq_data;
  logic [1:0]  a_num;

  logic b_req_val, b_resp_val, b_squash, b_deq_rdy;
  logic b_req_ok, b_resp_rdy, b_deq_val;
  mem_resp_4B_t b_msg;
  logic [31:0] b_deq_data;
  logic [2:0]  b_num;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  lab2_proc_imem_resp_unit #(.p_num_entries(2)) dut_a (
    .clk(clk), .reset(reset),
    .imemreq_val(a_req_val), .imemreq_rdy(req_rdy), .req_ok(a_req_ok),
    .imemresp_val(a_resp_val), .imemresp_rdy(a_resp_rdy), .imemresp_msg(a_msg),
    .squash(a_squash), .deq_val(a_deq_val), .deq_rdy(a_deq_rdy),
    .deq_data(a_deq_data), .num_outstanding(a_num)
  );

  lab2_proc_imem_resp_unit #(.p_num_entries(4)) dut_b (
    .clk(clk), .reset(reset),
    .imemreq_val(b_req_val), .imemreq_rdy(req_rdy), .req_ok(b_req_ok),
    .imemresp_val(b_resp_val), .imemresp_rdy(b_resp_rdy), .imemresp_msg(b_msg),
    .squash(b_squash), .deq_val(b_deq_val), .deq_rdy(b_deq_rdy),
    .deq_data(b_deq_data), .num_outstanding(b_num)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic a_drv(input logic rq, input logic rv, input logic [31:0] d,
                       input logic sq, input logic dr);
    a_req_val  = rq;
    a_resp_val = rv;
    a_msg      = '0;
    a_msg.data = d;
    a_squash   = sq;
    a_deq_rdy  = dr;
    #1;
  endtask

  task automatic b_drv(input logic rq, input logic rv, input logic [31:0] d,
                       input logic sq, input logic dr);
    b_req_val  = rq;
    b_resp_val = rv;
    b_msg      = '0;
    b_msg.data = d;
    b_squash   = sq;
    b_deq_rdy  = dr;
    #1;
  endtask

  function automatic logic [31:0] w(input int k);
    return 32'hC0DE_0000 + 32'(k);
  endfunction

  task automatic check_reset_a(input string tag);
    check({tag, "_a_deq_val"}, {31'd0, a_deq_val}, 32'd0);
    check({tag, "_a_req_ok"},  {31'd0, a_req_ok},  32'd1);
    check({tag, "_a_resp_rdy"},{31'd0, a_resp_rdy},32'd1);
    check({tag, "_a_num"},     {30'd0, a_num},     32'd0);
  endtask

  task automatic check_reset_b(input string tag);
    check({tag, "_b_deq_val"}, {31'd0, b_deq_val}, 32'd0);
    check({tag, "_b_req_ok"},  {31'd0, b_req_ok},  32'd1);
    check({tag, "_b_resp_rdy"},{31'd0, b_resp_rdy},32'd1);
    check({tag, "_b_num"},     {29'd0, b_num},     32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    a_drv(0, 0, 0, 0, 0);
    b_drv(0, 0, 0, 0, 0);
    step();
    step();
    check_reset_a("rst");
    check_reset_b("rst");
    reset = 1'b0;
    step();

    // Test 1: two back-to-back fetches, two responses, D always ready.
    a_drv(1, 0, 0, 0, 1);
    check("t1_req_ok0", {31'd0, a_req_ok}, 32'd1);
    step();
    a_drv(1, 0, 0, 0, 1);
    check("t1_req_ok1", {31'd0, a_req_ok}, 32'd1);
    check("t1_num1", {30'd0, a_num}, 32'd1);
    step();
    a_drv(0, 1, 32'h0000_0013, 0, 1);
    check("t1_req_ok2", {31'd0, a_req_ok}, 32'd0);
    check("t1_num2", {30'd0, a_num}, 32'd2);
    check("t1_resp_rdy", {31'd0, a_resp_rdy}, 32'd1);
    check("t1_c2_deq_val", {31'd0, a_deq_val}, {31'd0, c_bypass});
    step();
    a_drv(0, 1, 32'h0010_0093, 0, 1);
    check("t1_c3_deq_val", {31'd0, a_deq_val}, 32'd1);
    check("t1_c3_data", a_deq_data, c_bypass ? 32'h0010_0093 : 32'h0000_0013);
    step();
    a_drv(0, 0, 0, 0, 1);
    check("t1_c4_deq_val", {31'd0, a_deq_val}, {31'd0, !c_bypass});
    check("t1_c4_data", a_deq_val ? a_deq_data : 32'd0, c_bypass ? 32'd0 : 32'h0010_0093);
    check("t1_c4_num", {30'd0, a_num}, 32'd0);
    step();
    check("t1_c5_deq_val", {31'd0, a_deq_val}, 32'd0);

    // Test 2: D stalled with two responses buffered, then one dequeue frees a credit.
    a_drv(1, 0, 0, 0, 0);
    step();
    a_drv(1, 0, 0, 0, 0);
    step();
    a_drv(0, 1, 32'hAAAA_0001, 0, 0);
    step();
    a_drv(0, 1, 32'hAAAA_0002, 0, 0);
    step();
    a_drv(0, 0, 0, 0, 1);
    check("t2_req_ok_full", {31'd0, a_req_ok}, 32'd0);
    check("t2_num", {30'd0, a_num}, 32'd0);
    check("t2_resp_rdy_full", {31'd0, a_resp_rdy}, 32'd0);
    check("t2_head", a_deq_data, 32'hAAAA_0001);
    step();
    a_drv(0, 0, 0, 0, 0);
    check("t2_req_ok_after", {31'd0, a_req_ok}, 32'd1);
    check("t2_head2", a_deq_data, 32'hAAAA_0002);
    a_drv(0, 0, 0, 0, 1);
    step();
    a_drv(0, 0, 0, 0, 0);
    check("t2_drained", {31'd0, a_deq_val}, 32'd0);

    // Test 3 (depth 4): squash with two in flight while the redirect fetch fires.
    b_drv(1, 0, 0, 0, 1);
    step();
    b_drv(1, 0, 0, 0, 1);
    step();
    b_drv(1, 0, 0, 1, 1);
    check("t3_squash_req_ok", {31'd0, b_req_ok}, 32'd1);
    check("t3_squash_deq_val", {31'd0, b_deq_val}, 32'd0);
    step();
    b_drv(0, 1, 32'h1111_1111, 0, 1);
    check("t3_num_after_squash", {29'd0, b_num}, 32'd3);
    check("t3_drop1_rdy", {31'd0, b_resp_rdy}, 32'd1);
    check("t3_drop1_deq_val", {31'd0, b_deq_val}, 32'd0);
    step();
    b_drv(0, 1, 32'h2222_2222, 0, 1);
    check("t3_drop2_deq_val", {31'd0, b_deq_val}, 32'd0);
    step();
    b_drv(0, 1, 32'hDEAD_BEEF, 0, 1);
    check("t3_keep_deq_val", {31'd0, b_deq_val}, 32'd0 | {31'd0, c_bypass});
    step();
    b_drv(0, 0, 0, 0, 1);
    check("t3_next_deq_val", {31'd0, b_deq_val}, {31'd0, !c_bypass});
    check("t3_next_data", b_deq_val ? b_deq_data : 32'd0, c_bypass ? 32'd0 : 32'hDEAD_BEEF);
    check("t3_num", {29'd0, b_num}, 32'd0);
    step();
    b_drv(0, 0, 0, 0, 0);
    check("t3_drained", {31'd0, b_deq_val}, 32'd0);

    // Test 4: squash coinciding with the only outstanding response.
    a_drv(1, 0, 0, 0, 1);
    step();
    a_drv(0, 1, 32'h5555_5555, 1, 1);
    check("t4_rdy", {31'd0, a_resp_rdy}, 32'd1);
    check("t4_deq_val", {31'd0, a_deq_val}, 32'd0);
    step();
    a_drv(1, 0, 0, 0, 1);
    check("t4_num", {30'd0, a_num}, 32'd0);
    check("t4_empty", {31'd0, a_deq_val}, 32'd0);
    step();
    a_drv(0, 1, 32'h6666_6666, 0, 1);
    check("t4_nodrop_same", {31'd0, a_deq_val}, {31'd0, c_bypass});
    step();
    a_drv(0, 0, 0, 0, 0);
    check("t4_nodrop_next", {31'd0, a_deq_val}, {31'd0, !c_bypass});
    check("t4_nodrop_data", a_deq_val ? a_deq_data : 32'd0, c_bypass ? 32'd0 : 32'h6666_6666);
    a_drv(0, 0, 0, 0, 1);
    step();
    // Squash with nothing outstanding flushes a buffered word.
    a_drv(1, 0, 0, 0, 0);
    step();
    a_drv(0, 1, 32'h7777_7777, 0, 0);
    step();
    a_drv(0, 0, 0, 1, 0);
    check("t4_flush_sq_deq_val", {31'd0, a_deq_val}, 32'd0);
    step();
    a_drv(0, 0, 0, 0, 1);
    check("t4_flush_deq_val", {31'd0, a_deq_val}, 32'd0);
    check("t4_flush_req_ok", {31'd0, a_req_ok}, 32'd1);
    check("t4_flush_num", {30'd0, a_num}, 32'd0);
    step();
    a_drv(0, 0, 0, 0, 0);

    // Test 5 (depth 4): fill, then steady enq+deq for 10 cycles with wrap.
    for (int k = 0; k < 4; k++) begin
      b_drv(1, 0, 0, 0, 0);
      step();
    end
    for (int k = 0; k < 4; k++) begin
      b_drv(0, 1, w(k), 0, 0);
      step();
    end
    b_drv(0, 0, 0, 0, 0);
    check("t5_full_req_ok", {31'd0, b_req_ok}, 32'd0);
    check("t5_full_rdy", {31'd0, b_resp_rdy}, 32'd0);
    check("t5_full_num", {29'd0, b_num}, 32'd0);
    b_drv(0, 0, 0, 0, 1);
    check("t5_deq0", b_deq_data, w(0));
    step();
    b_drv(1, 0, 0, 0, 1);
    check("t5_req_ok_s1", {31'd0, b_req_ok}, 32'd1);
    check("t5_deq1", b_deq_data, w(1));
    step();
    for (int k = 2; k < 12; k++) begin
      b_drv(1, 1, w(k + 2), 0, 1);
      check($sformatf("t5_steady_val%0d", k), {31'd0, b_deq_val}, 32'd1);
      check($sformatf("t5_steady_deq%0d", k), b_deq_data, w(k));
      step();
    end
    b_drv(0, 1, w(14), 0, 1);
    check("t5_drain12", b_deq_data, w(12));
    step();
    b_drv(0, 0, 0, 0, 1);
    check("t5_drain13", b_deq_data, w(13));
    step();
    check("t5_drain14", b_deq_data, w(14));
    step();
    b_drv(0, 0, 0, 0, 0);
    check("t5_end_deq_val", {31'd0, b_deq_val}, 32'd0);
    check("t5_end_num", {29'd0, b_num}, 32'd0);

    // Test 6: single response into an empty queue, then reset mid-stream.
    a_drv(1, 0, 0, 0, 1);
    step();
    a_drv(0, 1, 32'h1234_5678, 0, 1);
    check("t6_same_val", {31'd0, a_deq_val}, {31'd0, c_bypass});
    check("t6_same_data", a_deq_val ? a_deq_data : 32'd0, c_bypass ? 32'h1234_5678 : 32'd0);
    step();
    a_drv(0, 0, 0, 0, 1);
    check("t6_next_val", {31'd0, a_deq_val}, {31'd0, !c_bypass});
    check("t6_next_data", a_deq_val ? a_deq_data : 32'd0, c_bypass ? 32'd0 : 32'h1234_5678);
    step();
    a_drv(1, 0, 0, 0, 0);
    b_drv(1, 0, 0, 0, 0);
    step();
    a_drv(1, 0, 0, 0, 0);
    b_drv(0, 0, 0, 0, 0);
    step();
    a_drv(0, 1, 32'hABCD_0000, 0, 0);
    step();
    a_drv(0, 0, 0, 0, 0);
    check("t6_pre_num", {30'd0, a_num}, 32'd1);
    check("t6_pre_deq_val", {31'd0, a_deq_val}, 32'd1);
    reset = 1'b1;
    step();
    check_reset_a("t6_midrst");
    check_reset_b("t6_midrst");
    reset = 1'b0;
    step();
    check("t6_post_deq_val", {31'd0, a_deq_val}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
